// File: rtl/spi_conf_rx_pkg.sv
// Shared opcodes, default frame length and FSM encoding for the SPI
// configuration receiver.
package spi_conf_rx_pkg;

    localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
    localparam logic [3:0] CMD_SET_DIVISOR = 4'b0010;
    localparam int         FRAME_BITS_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Bit counter holds at lim so over-long frames never wrap back to a valid count.
    function automatic logic [4:0] cnt_sat(input logic [4:0] cnt, input logic [4:0] lim);
        return (cnt >= lim) ? cnt : cnt + 5'd1;
    endfunction

endpackage

// File: rtl/spi_conf_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall strobes
// taken from the synchronized value.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic ck_1356meg,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  o_sync & ~r_prev;
    assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/spi_conf_rx.sv
// SPI slave receiving 16-bit command frames from the ARM; updates the
// configuration and divisor registers and returns a status byte on miso.
module spi_conf_rx
    import spi_conf_rx_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spck,
    input  logic       ncs,
    input  logic       mosi,
    input  logic [7:0] status_in,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       conf_stb,
    output logic       div_stb,
    output logic       frame_err
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS + 1);

    logic w_spck_sync, w_spck_rise, w_spck_fall;
    logic w_ncs_sync,  w_ncs_rise,  w_ncs_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
        .ck_1356meg(ck_1356meg), .rst(rst), .i_async(spck),
        .o_sync(w_spck_sync), .o_rise(w_spck_rise), .o_fall(w_spck_fall)
    );

    // ncs resets low so a frame already running at reset release never shows a fall.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
        .ck_1356meg(ck_1356meg), .rst(rst), .i_async(ncs),
        .o_sync(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .ck_1356meg(ck_1356meg), .rst(rst), .i_async(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_spck_sync, w_mosi_rise, w_mosi_fall};

    state_t      r_state, w_state_nxt;
    logic [15:0] r_rx, r_tx;
    logic [4:0]  r_cnt;
    logic [7:0]  r_conf_word, r_divisor;
    logic        r_conf_upd, r_div_upd, r_conf_stb, r_div_stb;
    logic        w_start, w_rx_shift, w_tx_shift, w_commit_conf, w_commit_div;

    always_ff @(posedge ck_1356meg) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_rx_shift    = 1'b0;
        w_tx_shift    = 1'b0;
        w_commit_conf = 1'b0;
        w_commit_div  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // An ncs rise swallows any spck edge seen in the same cycle.
                if (w_ncs_rise) begin
                    w_state_nxt = (r_cnt == CNT_FULL) ? ST_COMMIT : ST_ERR;
                end else begin
                    w_rx_shift = w_spck_rise;
                    w_tx_shift = w_spck_fall;
                end
            end
            ST_COMMIT: begin
                w_commit_conf = (r_rx[15:12] == CMD_SET_CONFREG);
                w_commit_div  = (r_rx[15:12] == CMD_SET_DIVISOR);
                w_state_nxt   = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            r_rx        <= '0;
            r_tx        <= '0;
            r_cnt       <= '0;
            r_conf_word <= '0;
            r_divisor   <= '0;
            r_conf_upd  <= 1'b0;
            r_div_upd   <= 1'b0;
            r_conf_stb  <= 1'b0;
            r_div_stb   <= 1'b0;
        end else begin
            if (w_start) begin
                r_rx  <= '0;
                r_cnt <= '0;
                r_tx  <= {status_in, 8'h00};
            end else begin
                if (w_rx_shift) begin
                    r_rx  <= {r_rx[14:0], w_mosi_sync};
                    r_cnt <= cnt_sat(r_cnt, CNT_MAX);
                end
                if (w_tx_shift) r_tx <= {r_tx[14:0], 1'b0};
            end
            if (w_commit_conf) r_conf_word <= r_rx[7:0];
            if (w_commit_div)  r_divisor   <= r_rx[7:0];
            // Strobes trail the register update by one cycle.
            r_conf_upd <= w_commit_conf;
            r_div_upd  <= w_commit_div;
            r_conf_stb <= r_conf_upd;
            r_div_stb  <= r_div_upd;
        end
    end

    assign miso      = ~w_ncs_sync & r_tx[15];
    assign conf_word = r_conf_word;
    assign divisor   = r_divisor;
    assign conf_stb  = r_conf_stb;
    assign div_stb   = r_div_stb;
    assign frame_err = (r_state == ST_ERR);

endmodule

// File: tb/tb_spi_conf_rx.sv
// Directed bench for spi_conf_rx: SPI frames at spck = clk/8 with a
// scoreboard of expected strobe events.
module tb_spi_conf_rx;

    typedef struct packed {
        logic [2:0] kind;   // {conf_stb, div_stb, frame_err}
        logic [7:0] val;
    } ev_t;

    localparam logic [2:0] K_CONF = 3'b100;
    localparam logic [2:0] K_DIV  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    logic       clk = 1'b0;
    logic       rst, spck, ncs, mosi;
    logic [7:0] status_in;
    logic       miso, conf_stb, div_stb, frame_err;
    logic [7:0] conf_word, divisor;

    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  sb_q[$];

    always #5 clk = ~clk;

    spi_conf_rx dut (
        .ck_1356meg(clk), .rst(rst), .spck(spck), .ncs(ncs), .mosi(mosi),
        .status_in(status_in), .miso(miso), .conf_word(conf_word),
        .divisor(divisor), .conf_stb(conf_stb), .div_stb(div_stb),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every strobe or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        ev_t obs_ev;
        ev_t exp_ev;
        if (rst === 1'b0 && (conf_stb === 1'b1 || div_stb === 1'b1 || frame_err === 1'b1)) begin
            obs_ev.kind = {conf_stb, div_stb, frame_err};
            obs_ev.val  = conf_stb ? conf_word : (div_stb ? divisor : 8'h00);
            if (sb_q.size() == 0) exp_ev = '0;
            else                  exp_ev = sb_q.pop_front();
            chk("sb_event", 32'(obs_ev), 32'(exp_ev));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ncs_low();
        ncs = 1'b0;
        wait_clk(4);
    endtask

    task automatic ncs_high();
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(12);
    endtask

    task automatic shift_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(4);
        m    = miso;
        spck = 1'b1;
        wait_clk(4);
        spck = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, output logic [31:0] cap);
        logic m;
        cap = '0;
        ncs_low();
        for (int i = nbits - 1; i >= 0; i--) begin
            shift_bit(data[i], m);
            cap = {cap[30:0], m};
        end
        ncs_high();
    endtask

    initial begin
        logic [31:0] cap;
        logic        m;
        logic [15:0] f;

        rst = 1'b1; spck = 1'b0; ncs = 1'b1; mosi = 1'b0; status_in = 8'h00;
        wait_clk(4);
        chk("rst_conf_word", 32'(conf_word), 32'h00);
        chk("rst_divisor",   32'(divisor),   32'h00);
        chk("rst_conf_stb",  32'(conf_stb),  32'h0);
        chk("rst_div_stb",   32'(div_stb),   32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_miso",      32'(miso),      32'h0);
        rst = 1'b0;
        wait_clk(6);

        // Config write with status byte returned on miso.
        status_in = 8'hA5;
        sb_q.push_back('{kind: K_CONF, val: 8'h25});
        send_frame(32'h1025, 16, cap);
        chk("conf_1025",     32'(conf_word), 32'h25);
        chk("div_after_1025", 32'(divisor),  32'h00);
        chk("miso_a5",       cap,            32'h0000_A500);
        chk("miso_idle",     32'(miso),      32'h0);

        status_in = 8'h3C;
        sb_q.push_back('{kind: K_DIV, val: 8'h07});
        send_frame(32'h2007, 16, cap);
        chk("div_2007",       32'(divisor),   32'h07);
        chk("conf_after_2007", 32'(conf_word), 32'h25);
        chk("miso_3c",        cap,            32'h0000_3C00);

        // Unknown opcode: silently ignored.
        send_frame(32'h3FFF, 16, cap);
        chk("conf_after_3fff", 32'(conf_word), 32'h25);
        chk("div_after_3fff",  32'(divisor),   32'h07);

        // Short and long frames.
        sb_q.push_back('{kind: K_ERR, val: 8'h00});
        send_frame(32'h0000_1055, 15, cap);
        sb_q.push_back('{kind: K_ERR, val: 8'h00});
        send_frame(32'h0001_2033, 17, cap);
        chk("conf_after_badlen", 32'(conf_word), 32'h25);
        chk("div_after_badlen",  32'(divisor),   32'h07);

        // ncs rise coincident with the 16th spck rise drops that bit.
        f = 16'h1099;
        sb_q.push_back('{kind: K_ERR, val: 8'h00});
        ncs_low();
        for (int i = 15; i >= 1; i--) shift_bit(f[i], m);
        mosi = f[0];
        wait_clk(4);
        spck = 1'b1;
        ncs  = 1'b1;
        wait_clk(4);
        spck = 1'b0;
        wait_clk(12);
        chk("conf_after_race", 32'(conf_word), 32'h25);
        chk("div_after_race",  32'(divisor),   32'h07);

        // Reset mid-frame: frame discarded, nothing reported.
        f = 16'h10FF;
        ncs_low();
        for (int i = 15; i >= 8; i--) shift_bit(f[i], m);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        chk("midrst_conf", 32'(conf_word), 32'h00);
        chk("midrst_div",  32'(divisor),   32'h00);
        for (int i = 7; i >= 0; i--) shift_bit(f[i], m);
        ncs_high();
        chk("midrst_conf_end", 32'(conf_word), 32'h00);

        sb_q.push_back('{kind: K_CONF, val: 8'h11});
        send_frame(32'h1011, 16, cap);
        chk("conf_1011", 32'(conf_word), 32'h11);
        chk("div_1011",  32'(divisor),   32'h00);

        wait_clk(8);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_conf_rx.md
SPI_CONF_RX -- requirements
Module: spi_conf_rx

Interface
REQ-001 Parameter: FRAME_BITS, default 16, number of SPI bits in one valid command frame.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth applied identically to spck, ncs and mosi.
REQ-003 Single clock domain, ck_1356meg; reset rst is synchronous and active-high.
REQ-004 ck_1356meg  in  1  system clock (13.56 MHz); all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 spck  in  1  SPI clock from the ARM, asynchronous to ck_1356meg.
REQ-007 ncs  in  1  SPI chip select, active-low, asynchronous.
REQ-008 mosi  in  1  SPI data in, MSB first, sampled on spck rising edge.
REQ-009 status_in  in  8  status byte returned to the ARM on miso during each frame.
REQ-010 miso  out  1  SPI data out, MSB first, updated on spck falling edge.
REQ-011 conf_word  out  8  configuration register, written by CMD_SET_CONFREG.
REQ-012 divisor  out  8  clock divisor register, written by CMD_SET_DIVISOR.
REQ-013 conf_stb  out  1  one-cycle pulse when conf_word is updated.
REQ-014 div_stb  out  1  one-cycle pulse when divisor is updated.
REQ-015 frame_err  out  1  one-cycle pulse when a frame is rejected.

Function
REQ-016 The block SHALL pass spck, ncs and mosi through SYNC_STAGES flops each and derive rise/fall strobes from the synchronized values.
REQ-017 The block SHALL support spck frequencies up to ck_1356meg/8; faster spck is outside spec.
REQ-018 FSM states SHALL be IDLE, SHIFT, COMMIT, ERR.
REQ-019 IDLE: on ncs fall, go to SHIFT, clear bit counter, load tx register with {status_in, 8'h00}.
REQ-020 SHIFT: on each spck rise, shift the synchronized mosi into bit 0 of a 16-bit rx register; increment the 5-bit bit counter, saturating at FRAME_BITS+1.
REQ-021 SHIFT: on each spck fall, shift the tx register left by one and fill with 0.
REQ-022 SHIFT: on ncs rise, go to COMMIT if bit counter == FRAME_BITS, else go to ERR.
REQ-023 An ncs rise and an spck edge in the same cycle: ncs rise wins and the spck edge is discarded.
REQ-024 spck edges while in IDLE, COMMIT or ERR SHALL be ignored.
REQ-025 COMMIT (one cycle): if rx[15:12]==CMD_SET_CONFREG, load conf_word <= rx[7:0] and pulse conf_stb.
REQ-026 COMMIT: if rx[15:12]==CMD_SET_DIVISOR, load divisor <= rx[7:0] and pulse div_stb.
REQ-027 COMMIT: any other opcode SHALL be ignored silently (no strobe, no error); then go to IDLE.
REQ-028 ERR (one cycle): pulse frame_err, leave both registers unchanged, go to IDLE.
REQ-029 Strobes SHALL assert exactly one cycle after the registered value changes and never simultaneously with each other.
REQ-030 miso SHALL equal tx[15] while synchronized ncs is low, else 0.

Reset
REQ-031 rst SHALL force IDLE; conf_word=0, divisor=0, conf_stb=0, div_stb=0, frame_err=0, miso=0; counter and shift registers cleared.
REQ-032 Synchronizer flops for ncs SHALL reset to 0 so that a frame in progress at reset release produces no false ncs fall; the block SHALL accept frames only after ncs is seen high and then low again.
REQ-033 Reset asserted mid-frame SHALL discard the frame without any strobe or frame_err.

Structure
REQ-034 A shared package SHALL hold CMD_SET_CONFREG=4'b0001, CMD_SET_DIVISOR=4'b0010, the default FRAME_BITS, and the FSM state encoding.
REQ-035 One sub-module, sync_edge (synchronizer plus rise/fall detect), SHALL be instantiated for each of spck, ncs and mosi.

Verification
REQ-036 Frame 0x1025 at spck=ck/8 -> conf_word=0x25, one conf_stb pulse, divisor unchanged, no frame_err.
REQ-037 Frame 0x2007 -> divisor=0x07, one div_stb pulse; then frame 0x3FFF -> no strobe, no frame_err, registers unchanged.
REQ-038 Frame of 15 bits, then a frame of 17 bits -> two frame_err pulses, conf_word and divisor unchanged.
REQ-039 status_in=0xA5 during a frame -> miso carries 1,0,1,0,0,1,0,1 then eight 0s over the 16 spck falling edges.
REQ-040 rst pulsed after 8 bits of frame 0x10FF, ncs held low to the end of the frame -> no strobe, no frame_err; next full frame 0x1011 -> conf_word=0x11.
REQ-041 ncs rise in the same cycle as the 16th synchronized spck rise -> bit discarded, counter=15, frame_err pulse.
